id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection and branch-flush bubble insertion. It sits between the decode stage and execute. It registers decoded fields and control bits, and its rs1/rs2/rd/RegWrite outputs feed the EX-stage forwarding unit and the EX/MEM register. It also drives the PC and IF/ID write-enables that stall the front end for one cycle on a load-use hazard.

---
 rtl/riscv_pipe_pkg.sv | 54 +++++
 rtl/id_ex_stage_if.sv | 69 ++++++
 rtl/id_ex_stage_hazard_detect.sv | 42 ++++
 rtl/id_ex_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: datapath widths, ALUOp classes and the ID/EX control bundle.
package riscv_pipe_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REGW      = 5;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned CNTW_DFLT = 16;

    // ALU operation class handed from decode to the ALU control unit
    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluop_e;

    // Control bits that travel together through ID/EX
    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   alu_src;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // A bubble carries no side effects: every control bit is zero
    localparam ctrl_t BUBBLE_CTRL = '0;

    // Gather loose decode outputs into one control bundle
    function automatic ctrl_t make_ctrl(
        input logic               reg_write,
        input logic               mem_read,
        input logic               mem_write,
        input logic               mem_to_reg,
        input logic               alu_src,
        input logic               branch,
        input logic [ALUOP_W-1:0] alu_op
    );
        ctrl_t c;
        c.reg_write  = reg_write;
        c.mem_read   = mem_read;
        c.mem_write  = mem_write;
        c.mem_to_reg = mem_to_reg;
        c.alu_src    = alu_src;
        c.branch     = branch;
        c.alu_op     = aluop_e'(alu_op);
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ID-side fields in, registered ID/EX fields and front-end enables out.
interface id_ex_stage_if
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CNTW = CNTW_DFLT
) ();

    logic [REGW-1:0]    rs1_ID;
    logic [REGW-1:0]    rs2_ID;
    logic [REGW-1:0]    rd_ID;
    logic               uses_rs1_ID;
    logic               uses_rs2_ID;
    logic               RegWrite_ID;
    logic               MemRead_ID;
    logic               MemWrite_ID;
    logic               MemtoReg_ID;
    logic               ALUSrc_ID;
    logic               Branch_ID;
    logic [ALUOP_W-1:0] ALUOp_ID;
    logic [XLEN-1:0]    rs1_data_ID;
    logic [XLEN-1:0]    rs2_data_ID;
    logic [XLEN-1:0]    imm_ID;
    logic [XLEN-1:0]    pc_ID;
    logic               valid_ID;
    logic               flush_EX;

    logic [REGW-1:0]    rs1_IDEX;
    logic [REGW-1:0]    rs2_IDEX;
    logic [REGW-1:0]    rd_IDEX;
    logic               RegWrite_IDEX;
    logic               MemRead_IDEX;
    logic               MemWrite_IDEX;
    logic               MemtoReg_IDEX;
    logic               ALUSrc_IDEX;
    logic               Branch_IDEX;
    logic [ALUOP_W-1:0] ALUOp_IDEX;
    logic [XLEN-1:0]    rs1_data_IDEX;
    logic [XLEN-1:0]    rs2_data_IDEX;
    logic [XLEN-1:0]    imm_IDEX;
    logic [XLEN-1:0]    pc_IDEX;
    logic               valid_IDEX;
    logic               PCWrite;
    logic               IFIDWrite;
    logic [CNTW-1:0]    stall_cnt;
    logic [CNTW-1:0]    flush_cnt;

    // Decode/branch side: drives ID fields, observes the stage
    modport master (
        output rs1_ID, rs2_ID, rd_ID, uses_rs1_ID, uses_rs2_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID, ALUOp_ID,
               rs1_data_ID, rs2_data_ID, imm_ID, pc_ID, valid_ID, flush_EX,
        input  rs1_IDEX, rs2_IDEX, rd_IDEX,
               RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX, ALUOp_IDEX,
               rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, pc_IDEX, valid_IDEX,
               PCWrite, IFIDWrite, stall_cnt, flush_cnt
    );

    // The ID/EX stage itself
    modport slave (
        input  rs1_ID, rs2_ID, rd_ID, uses_rs1_ID, uses_rs2_ID,
               RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID, Branch_ID, ALUOp_ID,
               rs1_data_ID, rs2_data_ID, imm_ID, pc_ID, valid_ID, flush_EX,
        output rs1_IDEX, rs2_IDEX, rd_IDEX,
               RegWrite_IDEX, MemRead_IDEX, MemWrite_IDEX, MemtoReg_IDEX, ALUSrc_IDEX, Branch_IDEX, ALUOp_IDEX,
               rs1_data_IDEX, rs2_data_IDEX, imm_IDEX, pc_IDEX, valid_IDEX,
               PCWrite, IFIDWrite, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: purely combinational, flush overrides stall.
module hazard_detect
    import riscv_pipe_pkg::*;
(
    input  logic            i_valid_idex,
    input  logic            i_mem_read_idex,
    input  logic [REGW-1:0] i_rd_idex,
    input  logic [REGW-1:0] i_rs1_id,
    input  logic [REGW-1:0] i_rs2_id,
    input  logic            i_uses_rs1_id,
    input  logic            i_uses_rs2_id,
    input  logic            i_valid_id,
    input  logic            i_flush_ex,
    output logic            o_load_use_c,
    output logic            o_stall_c,
    output logic            o_pc_write_c,
    output logic            o_ifid_write_c
);

    logic w_rs1_match;
    logic w_rs2_match;

    // A load into x0 never produces a value worth waiting for
    always_comb begin
        w_rs1_match    = 1'b0;
        w_rs2_match    = 1'b0;
        o_load_use_c   = 1'b0;
        o_stall_c      = 1'b0;
        o_pc_write_c   = 1'b1;
        o_ifid_write_c = 1'b1;

        w_rs1_match  = i_uses_rs1_id && (i_rd_idex == i_rs1_id);
        w_rs2_match  = i_uses_rs2_id && (i_rd_idex == i_rs2_id);
        o_load_use_c = i_valid_idex && i_mem_read_idex && (i_rd_idex != '0)
                     && (w_rs1_match || w_rs2_match) && i_valid_id;
        // A wrong-path ID instruction is squashed anyway, so no point freezing the front end
        o_stall_c      = o_load_use_c && !i_flush_ex;
        o_pc_write_c   = !o_stall_c;
        o_ifid_write_c = !o_stall_c;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on load-use stall or branch flush.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CNTW = CNTW_DFLT
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);

    ctrl_t           r_ctrl;
    logic [REGW-1:0] r_rs1;
    logic [REGW-1:0] r_rs2;
    logic [REGW-1:0] r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic [CNTW-1:0] r_stall_cnt;
    logic [CNTW-1:0] r_flush_cnt;

    ctrl_t           w_ctrl_id;
    logic            w_load_use;
    logic            w_stall;
    logic            w_bubble;

    hazard_detect u_hazard (
        .i_valid_idex    (r_valid),
        .i_mem_read_idex (r_ctrl.mem_read),
        .i_rd_idex       (r_rd),
        .i_rs1_id        (bus.rs1_ID),
        .i_rs2_id        (bus.rs2_ID),
        .i_uses_rs1_id   (bus.uses_rs1_ID),
        .i_uses_rs2_id   (bus.uses_rs2_ID),
        .i_valid_id      (bus.valid_ID),
        .i_flush_ex      (bus.flush_EX),
        .o_load_use_c    (w_load_use),
        .o_stall_c       (w_stall),
        .o_pc_write_c    (bus.PCWrite),
        .o_ifid_write_c  (bus.IFIDWrite)
    );

    // Bundle decode controls and decide whether this edge loads a bubble
    always_comb begin
        w_ctrl_id = make_ctrl(bus.RegWrite_ID, bus.MemRead_ID, bus.MemWrite_ID,
                              bus.MemtoReg_ID, bus.ALUSrc_ID, bus.Branch_ID, bus.ALUOp_ID);
        w_bubble  = bus.flush_EX || w_load_use;
    end

    // Pipeline register: reset, then bubble, then normal load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= BUBBLE_CTRL;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_valid    <= 1'b0;
        end else if (w_bubble) begin
            r_ctrl     <= BUBBLE_CTRL;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_valid    <= 1'b0;
        end else begin
            // Empty ID slot still carries its data, but nothing that could write or be forwarded
            r_ctrl     <= bus.valid_ID ? w_ctrl_id  : BUBBLE_CTRL;
            r_rs1      <= bus.valid_ID ? bus.rs1_ID : '0;
            r_rs2      <= bus.valid_ID ? bus.rs2_ID : '0;
            r_rd       <= bus.valid_ID ? bus.rd_ID  : '0;
            r_rs1_data <= bus.rs1_data_ID;
            r_rs2_data <= bus.rs2_data_ID;
            r_imm      <= bus.imm_ID;
            r_pc       <= bus.pc_ID;
            r_valid    <= bus.valid_ID;
        end
    end

    // Saturating stall/flush event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != {CNTW{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNTW'(1);
            end
            if (bus.flush_EX && (r_flush_cnt != {CNTW{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNTW'(1);
            end
        end
    end

    // Drive registered state onto the bus
    always_comb begin
        bus.rs1_IDEX      = r_rs1;
        bus.rs2_IDEX      = r_rs2;
        bus.rd_IDEX       = r_rd;
        bus.RegWrite_IDEX = r_ctrl.reg_write;
        bus.MemRead_IDEX  = r_ctrl.mem_read;
        bus.MemWrite_IDEX = r_ctrl.mem_write;
        bus.MemtoReg_IDEX = r_ctrl.mem_to_reg;
        bus.ALUSrc_IDEX   = r_ctrl.alu_src;
        bus.Branch_IDEX   = r_ctrl.branch;
        bus.ALUOp_IDEX    = r_ctrl.alu_op;
        bus.rs1_data_IDEX = r_rs1_data;
        bus.rs2_data_IDEX = r_rs2_data;
        bus.imm_IDEX      = r_imm;
        bus.pc_IDEX       = r_pc;
        bus.valid_IDEX    = r_valid;
        bus.stall_cnt     = r_stall_cnt;
        bus.flush_cnt     = r_flush_cnt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a random stream against a behavioural model.
module tb_id_ex_stage;

    localparam int unsigned TB_CNTW = 4;
    localparam int          SAT     = 15;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        uses1;
        logic        uses2;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic        asrc;
        logic        br;
        logic [1:0]  aluop;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        valid;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.CNTW(TB_CNTW)) bus ();
    id_ex_stage #(.CNTW(TB_CNTW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    // Model: what the ID/EX slot should hold, and the event counts so far
    instr_t m;
    int     sc;
    int     fc;

    function automatic instr_t capture();
        instr_t g;
        g.rs1 = bus.rs1_IDEX;  g.rs2 = bus.rs2_IDEX;  g.rd = bus.rd_IDEX;
        g.uses1 = 1'b0;        g.uses2 = 1'b0;
        g.rw = bus.RegWrite_IDEX; g.mr = bus.MemRead_IDEX; g.mw = bus.MemWrite_IDEX;
        g.m2r = bus.MemtoReg_IDEX; g.asrc = bus.ALUSrc_IDEX; g.br = bus.Branch_IDEX;
        g.aluop = bus.ALUOp_IDEX;
        g.d1 = bus.rs1_data_IDEX; g.d2 = bus.rs2_data_IDEX;
        g.imm = bus.imm_IDEX; g.pc = bus.pc_IDEX; g.valid = bus.valid_IDEX;
        return g;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.rs1 = 5'($urandom_range(0, 3)); i.rs2 = 5'($urandom_range(0, 3)); i.rd = 5'($urandom_range(0, 3));
        i.uses1 = 1'($urandom); i.uses2 = 1'($urandom);
        i.rw = 1'($urandom); i.mr = ($urandom_range(0, 9) < 4); i.mw = 1'($urandom);
        i.m2r = 1'($urandom); i.asrc = 1'($urandom); i.br = 1'($urandom);
        i.aluop = 2'($urandom);
        i.d1 = $urandom; i.d2 = $urandom; i.imm = $urandom; i.pc = $urandom;
        i.valid = ($urandom_range(0, 9) < 8);
        return i;
    endfunction

    function automatic instr_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic u1, input logic u2, input logic load);
        instr_t i;
        i = rand_instr();
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.uses1 = u1; i.uses2 = u2;
        i.mr = load; i.rw = 1'b1; i.valid = 1'b1;
        return i;
    endfunction

    // ID instruction must wait if the slot ahead is a real load into a register it reads
    function automatic logic ref_load_use(input instr_t ex, input instr_t id);
        return ex.valid && ex.mr && (ex.rd != 0) && id.valid
            && ((id.uses1 && id.rs1 == ex.rd) || (id.uses2 && id.rs2 == ex.rd));
    endfunction

    // Drive one cycle, capture front-end enables before the edge, advance the model
    task automatic apply(input instr_t ins, input logic fl, input logic r,
                         output logic exp_pcw, output logic got_pcw, output logic got_ifid);
        bus.rs1_ID = ins.rs1; bus.rs2_ID = ins.rs2; bus.rd_ID = ins.rd;
        bus.uses_rs1_ID = ins.uses1; bus.uses_rs2_ID = ins.uses2;
        bus.RegWrite_ID = ins.rw; bus.MemRead_ID = ins.mr; bus.MemWrite_ID = ins.mw;
        bus.MemtoReg_ID = ins.m2r; bus.ALUSrc_ID = ins.asrc; bus.Branch_ID = ins.br;
        bus.ALUOp_ID = ins.aluop;
        bus.rs1_data_ID = ins.d1; bus.rs2_data_ID = ins.d2; bus.imm_ID = ins.imm; bus.pc_ID = ins.pc;
        bus.valid_ID = ins.valid; bus.flush_EX = fl; rst = r;
        #1;
        exp_pcw  = !(ref_load_use(m, ins) && !fl);
        got_pcw  = bus.PCWrite;
        got_ifid = bus.IFIDWrite;
        if (r) begin
            m = '0; sc = 0; fc = 0;
        end else begin
            if (fl && fc < SAT) fc++;
            if (!exp_pcw && sc < SAT) sc++;
            if (fl || !exp_pcw) begin
                m = '0;
            end else if (!ins.valid) begin
                m = '0;
                m.d1 = ins.d1; m.d2 = ins.d2; m.imm = ins.imm; m.pc = ins.pc;
            end else begin
                m = ins; m.uses1 = 1'b0; m.uses2 = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic e, p, f;
        apply(rand_instr(), 1'b0, 1'b1, e, p, f);
        apply(rand_instr(), 1'b0, 1'b1, e, p, f);
    endtask

    task automatic test_reset();
        logic e, p, f;
        instr_t zero;
        zero = '0;
        apply(rand_instr(), 1'($urandom), 1'b1, e, p, f);
        apply(rand_instr(), 1'($urandom), 1'b1, e, p, f);
        rst = 1'b0;
        #1;
        checks++;
        if (capture() !== zero) begin errors++; $display("FAIL reset_regs got=%h exp=%h", capture(), zero); end
        checks++;
        if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
        end
        checks++;
        if (bus.PCWrite !== 1'b1 || bus.IFIDWrite !== 1'b1) begin
            errors++; $display("FAIL reset_we got=%b%b exp=11", bus.PCWrite, bus.IFIDWrite);
        end
    endtask

    task automatic test_load_use();
        logic e, p, f;
        instr_t add;
        do_reset();
        apply(mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0, e, p, f);
        add = mk(5'd5, 5'd9, 5'd6, 1'b1, 1'b1, 1'b0);
        apply(add, 1'b0, 1'b0, e, p, f);
        checks++;
        if (p !== 1'b0 || f !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b%b exp=00", p, f); end
        checks++;
        if (bus.valid_IDEX !== 1'b0 || capture() !== m) begin
            errors++; $display("FAIL lu_bubble got=%h exp=%h", capture(), m);
        end
        apply(add, 1'b0, 1'b0, e, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL lu_resume got=%b exp=1", p); end
        checks++;
        if (bus.rs1_IDEX !== 5'd5 || bus.valid_IDEX !== 1'b1 || bus.pc_IDEX !== add.pc) begin
            errors++; $display("FAIL lu_reissue got=%0d pc=%h exp=5 pc=%h", bus.rs1_IDEX, bus.pc_IDEX, add.pc);
        end
        checks++;
        if (bus.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", bus.stall_cnt); end
    endtask

    task automatic test_no_false_stall();
        logic e, p, f;
        do_reset();
        apply(mk(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0, e, p, f);
        apply(mk(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, e, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL nfs_x0 got=%b exp=1", p); end
        apply(mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0, e, p, f);
        apply(mk(5'd7, 5'd5, 5'd3, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, e, p, f);
        checks++;
        if (p !== 1'b1 || f !== 1'b1) begin errors++; $display("FAIL nfs_unused got=%b%b exp=11", p, f); end
        checks++;
        if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL nfs_cnt got=%0d exp=0", bus.stall_cnt); end
    endtask

    task automatic test_flush_priority();
        logic e, p, f;
        instr_t zero;
        zero = '0;
        do_reset();
        apply(mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0, e, p, f);
        apply(mk(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0), 1'b1, 1'b0, e, p, f);
        checks++;
        if (p !== 1'b1 || f !== 1'b1) begin errors++; $display("FAIL fp_we got=%b%b exp=11", p, f); end
        checks++;
        if (capture() !== zero) begin errors++; $display("FAIL fp_bubble got=%h exp=%h", capture(), zero); end
        checks++;
        if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd0) begin
            errors++; $display("FAIL fp_cnt got=%0d/%0d exp=1/0", bus.flush_cnt, bus.stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic e, p, f;
        instr_t add;
        do_reset();
        apply(mk(5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0, e, p, f);
        add = mk(5'd4, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        apply(add, 1'b0, 1'b1, e, p, f);
        apply(add, 1'b0, 1'b0, e, p, f);
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL rms_we got=%b exp=1", p); end
        checks++;
        if (bus.stall_cnt !== 4'd0 || bus.rs1_IDEX !== 5'd4) begin
            errors++; $display("FAIL rms_state got=%0d rs1=%0d exp=0 rs1=4", bus.stall_cnt, bus.rs1_IDEX);
        end
    endtask

    task automatic test_saturation();
        logic e, p, f;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(rand_instr(), 1'b1, 1'b0, e, p, f);
            if (i == 14) begin
                checks++;
                if (bus.flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got=%0d exp=15", bus.flush_cnt); end
            end
        end
        checks++;
        if (bus.flush_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", bus.flush_cnt); end
    endtask

    task automatic test_pass_through();
        logic e, p, f;
        instr_t ins, exp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ins = rand_instr();
            ins.valid = 1'b1; ins.mr = 1'b0;
            ins.imm = 32'h1000_0000 + 32'(i); ins.pc = 32'h0000_4000 + 32'(4 * i);
            apply(ins, 1'b0, 1'b0, e, p, f);
            exp = ins; exp.uses1 = 1'b0; exp.uses2 = 1'b0;
            checks++;
            if (p !== 1'b1 || capture() !== exp) begin
                errors++; $display("FAIL pass_%0d we=%b got=%h exp=%h", i, p, capture(), exp);
            end
        end
        checks++;
        if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL pass_cnt got=%0d exp=0", bus.stall_cnt); end
    endtask

    task automatic test_random();
        logic e, p, f, r, fl;
        instr_t ins;
        do_reset();
        e = 1'b1;
        ins = rand_instr();
        for (int i = 0; i < 300; i++) begin
            if (e) ins = rand_instr();
            fl = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 49) == 0);
            apply(ins, fl, r, e, p, f);
            checks++;
            if (p !== e || f !== e) begin errors++; $display("FAIL rnd_we_%0d got=%b%b exp=%b", i, p, f, e); end
            checks++;
            if (capture() !== m) begin errors++; $display("FAIL rnd_regs_%0d got=%h exp=%h", i, capture(), m); end
            checks++;
            if (bus.stall_cnt !== 4'(sc) || bus.flush_cnt !== 4'(fc)) begin
                errors++; $display("FAIL rnd_cnt_%0d got=%0d/%0d exp=%0d/%0d", i, bus.stall_cnt, bus.flush_cnt, sc, fc);
            end
            if (r) e = 1'b1;
        end
    endtask

    initial begin
        m = '0; sc = 0; fc = 0;
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_reset_mid_stall();
        test_saturation();
        test_pass_through();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
